// File: rtl/lsu_pkg.sv
// Shared types for the load/store sequencer: access encodings, FSM states, latched access payload.
package lsu_pkg;

  localparam int unsigned XLEN                   = 32;
  localparam int unsigned BE_W                   = XLEN / 8;
  localparam int unsigned CNT_W                  = 8;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b011,
    LD_LHU = 3'b100
  } load_e;

  typedef enum logic [1:0] {
    ST_SB = 2'b00,
    ST_SH = 2'b01,
    ST_SW = 2'b10
  } store_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // One memory access as captured when the sequencer leaves IDLE.
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    load_e           load_src;
    store_e          store_src;
    logic            we;
  } acc_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: alignment check, byte enables, store-data replication and load extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]      addr_lo_i,
  input  logic            we_i,
  input  load_e           load_src_i,
  input  store_e          store_src_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic            aligned_o,
  output logic [BE_W-1:0] be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] ext_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half out of the returned word.
  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'b01:   byte_sel = rdata_i[15:8];
      2'b10:   byte_sel = rdata_i[23:16];
      2'b11:   byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    aligned_o = 1'b1;
    be_o      = '1;
    wdata_o   = wdata_i;
    ext_o     = '0;
    if (we_i) begin
      case (store_src_i)
        ST_SB: begin
          be_o    = 4'b0001 << addr_lo_i;
          wdata_o = {4{wdata_i[7:0]}};
        end
        ST_SH: begin
          aligned_o = ~addr_lo_i[0];
          be_o      = 4'b0011 << addr_lo_i;
          wdata_o   = {2{wdata_i[15:0]}};
        end
        default: aligned_o = (addr_lo_i == 2'b00);
      endcase
    end else begin
      case (load_src_i)
        LD_LB:  ext_o = {{24{byte_sel[7]}}, byte_sel};
        LD_LBU: ext_o = {24'b0, byte_sel};
        LD_LH: begin
          aligned_o = ~addr_lo_i[0];
          ext_o     = {{16{half_sel[15]}}, half_sel};
        end
        LD_LHU: begin
          aligned_o = ~addr_lo_i[0];
          ext_o     = {16'b0, half_sel};
        end
        default: begin
          aligned_o = (addr_lo_i == 2'b00);
          ext_o     = rdata_i;
        end
      endcase
    end
  end

endmodule

// File: rtl/lsu_sequencer.sv
// Load/store sequencer: IDLE -> REQ -> DONE handshake with a single-port memory.
// Optional memReady timeout enabled by defining LSU_TIMEOUT_EN.
module lsu_sequencer
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  loadSrc,
  input  logic [1:0]  storeSrc,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic        misaligned,
  output logic        busErr,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [3:0]  memBe,
  output logic [31:0] memWdata,
  input  logic        memReady,
  input  logic [31:0] memRdata
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("lsu_sequencer: TIMEOUT_CYCLES must be within 1..255");
  end

  state_e          state_q, state_d;
  acc_t            acc_q, acc_live;
  logic [XLEN-1:0] rdata_q;
  logic            access_c, accept_c, timeout_hit;

  logic [1:0]      al_addr_lo;
  logic            al_we;
  load_e           al_load;
  store_e          al_store;
  logic [XLEN-1:0] al_wdata_in;
  logic            al_aligned;
  logic [BE_W-1:0] al_be;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_ext;

  // A simultaneous read+write request is treated as a write.
  assign acc_live = '{addr:      addr,
                      wdata:     wdata,
                      load_src:  load_e'(loadSrc),
                      store_src: store_e'(storeSrc),
                      we:        memWrite};

  // IDLE checks the live request; REQ drives lanes from the latched one.
  assign al_addr_lo  = (state_q == S_IDLE) ? acc_live.addr[1:0]  : acc_q.addr[1:0];
  assign al_we       = (state_q == S_IDLE) ? acc_live.we         : acc_q.we;
  assign al_load     = (state_q == S_IDLE) ? acc_live.load_src   : acc_q.load_src;
  assign al_store    = (state_q == S_IDLE) ? acc_live.store_src  : acc_q.store_src;
  assign al_wdata_in = (state_q == S_IDLE) ? acc_live.wdata      : acc_q.wdata;

  lsu_align u_align (
    .addr_lo_i   (al_addr_lo),
    .we_i        (al_we),
    .load_src_i  (al_load),
    .store_src_i (al_store),
    .wdata_i     (al_wdata_in),
    .rdata_i     (memRdata),
    .aligned_o   (al_aligned),
    .be_o        (al_be),
    .wdata_o     (al_wdata),
    .ext_o       (al_ext)
  );

  assign access_c = memRead | memWrite;
  assign accept_c = (state_q == S_IDLE) & access_c & al_aligned;

`ifdef LSU_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // Counts REQ cycles that went by without memReady.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if (accept_c) begin
        cnt_q <= '0;
      end else if ((state_q == S_REQ) && !memReady) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign timeout_hit = (state_q == S_REQ) && !memReady &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign busErr      = (state_q == S_DONE) && err_q;
`else
  assign timeout_hit = 1'b0;
  assign busErr      = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_c) state_d = S_REQ;
      S_REQ:   if (memReady || timeout_hit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall      = 1'b0;
    misaligned = 1'b0;
    done       = 1'b0;
    memReq     = 1'b0;
    memWe      = 1'b0;
    memAddr    = '0;
    memBe      = '0;
    memWdata   = '0;
    case (state_q)
      S_IDLE: begin
        misaligned = access_c & ~al_aligned;
        stall      = access_c & al_aligned;
      end
      S_REQ: begin
        stall    = 1'b1;
        memReq   = 1'b1;
        memWe    = acc_q.we;
        memAddr  = {acc_q.addr[XLEN-1:2], 2'b00};
        memBe    = al_be;
        memWdata = al_wdata;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Access capture and load-result register; a timeout returns zero.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      acc_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (accept_c) begin
        acc_q <= acc_live;
      end
      if ((state_q == S_REQ) && memReady) begin
        rdata_q <= acc_q.we ? '0 : al_ext;
      end else if (timeout_hit) begin
        rdata_q <= '0;
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: doc/lsu_sequencer.md
LSU_SEQUENCER -- requirements
Module: lsu_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, maximum memReady wait in REQ before abort; range 1..255 (counter is 8 bits).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 resetN  in  1  asynchronous active-low reset.
REQ-004 memRead, memWrite  in  1 each  access request for the current instruction, from the main decoder.
REQ-005 loadSrc  in  3  load type: 000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu.
REQ-006 storeSrc  in  2  store type: 00 sb, 01 sh, 10 sw.
REQ-007 addr  in  32  byte address from the ALU; wdata  in  32  rs2 store data.
REQ-008 stall  out  1  freeze PC and register-file write.
REQ-009 rdata  out  32  extended load result, valid while done=1.
REQ-010 done  out  1  one-cycle completion pulse; misaligned  out  1  alignment fault; busErr  out  1  timeout pulse.
REQ-011 memReq, memWe  out  1 each; memAddr  out  32; memBe  out  4; memWdata  out  32  memory-side request, held stable until accepted.
REQ-012 memReady  in  1  accept/complete strobe; memRdata  in  32  read word, valid with memReady.

Function
REQ-013 FSM states: IDLE, REQ, DONE.
REQ-014 IDLE: an aligned access (memRead|memWrite) latches addr, wdata, type and write flag, asserts stall combinationally the same cycle, and moves to REQ.
REQ-015 If memRead and memWrite are both 1, the access is a write.
REQ-016 Alignment: lh/lhu/sh need addr[0]=0; lw/sw need addr[1:0]=00; byte accesses are always aligned.
REQ-017 Misaligned access in IDLE: misaligned=1 combinationally, stall=0, no memReq, state stays IDLE.
REQ-018 REQ: memReq=1, memAddr={addr[31:2],2'b00}, memWe=write flag, stall=1; all memory-side outputs constant while waiting.
REQ-019 memBe: sb 0001<<addr[1:0]; sh 0011<<addr[1:0]; sw 1111; loads 1111.
REQ-020 memWdata: sb byte replicated x4; sh half replicated x2; sw unchanged.
REQ-021 REQ with memReady=1: capture the extended load data into an rdata register and go to DONE.
REQ-022 Load extension: byte/half selected by addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend, lw unchanged; stores capture 0.
REQ-023 DONE: done=1, stall=0, memReq=0; memRead/memWrite ignored; next state is IDLE unconditionally.
REQ-024 Latency: with memReady in the first REQ cycle, the instruction occupies 3 cycles (IDLE, REQ, DONE); each extra wait cycle adds 1.
REQ-025 Outside REQ: memReq=0, memBe=0000, memWe=0.

Reset
REQ-026 resetN low: state IDLE, rdata register 0, timeout counter 0, and memReq/memWe/done/busErr=0 immediately, including mid-REQ; an abandoned transaction is not resumed.
REQ-027 After resetN deasserts, the first accepted request is evaluated on the next rising edge.

Configuration
REQ-028 Macro LSU_TIMEOUT_EN defined: an 8-bit counter clears on REQ entry and increments each REQ cycle without memReady.
REQ-029 With LSU_TIMEOUT_EN, reaching TIMEOUT_CYCLES drops memReq and goes to DONE with busErr=1 for that cycle and rdata=0.
REQ-030 With LSU_TIMEOUT_EN, memReady in the same cycle as the limit takes precedence and completes normally.
REQ-031 Without LSU_TIMEOUT_EN: the counter is absent, busErr is tied 0, and the REQ wait is unbounded.

Structure
REQ-032 Shared package lsu_pkg holds the loadSrc/storeSrc encodings as enums, the FSM state enum and the default TIMEOUT_CYCLES.
REQ-033 Sub-module lsu_align (combinational) computes memBe, memWdata, alignment check and load extension; the FSM and registers live in lsu_sequencer.

Verification
REQ-034 lw addr=0x100, memReady after 2 wait cycles, memRdata=0xDEADBEEF -> stall 4 cycles, then done with rdata=0xDEADBEEF.
REQ-035 lb addr=0x103, memRdata=0x80000000 -> memBe=1111, rdata=0xFFFFFF80; lbu at the same address -> rdata=0x00000080.
REQ-036 sh addr=0x202, wdata=0x1234ABCD -> memBe=1100, memWdata=0xABCDABCD, memWe=1.
REQ-037 lw addr=0x101 -> misaligned=1, stall=0, memReq never asserted.
REQ-038 resetN pulsed low mid-REQ -> memReq=0 asynchronously, state IDLE; the next sw completes normally.
REQ-039 With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, memReady held 0 -> busErr pulse on the cycle after the 4th REQ cycle, rdata=0, then IDLE.
